gray_conv_arbiter: RTL
======================

Name: gray_conv_arbiter

Overview:
- Shares one registered binary/Gray code converter between 4 requesters using round-robin arbitration.
- Each requester selects its own conversion direction: binary->Gray or Gray->binary.
- Results are returned through a single valid/ready response port, tagged with the requester ID.
- Sits between address/pointer producers (counters, FIFO pointer logic) and the shared code-conversion datapath.

Parameters:
- WIDTH, 4, data width of each request and of the result (>=2).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  4  per-requester request; bit i = requester i
- req_data  input  4*WIDTH  requester i operand in bits [i*WIDTH +: WIDTH]
- req_mode  input  4  per-requester direction: 0 = binary->Gray, 1 = Gray->binary
- gnt  output  4  one-hot accept strobe, combinational, same cycle as acceptance
- rsp_valid  output  1  result register holds valid data
- rsp_id  output  2  index of the requester that owns the result
- rsp_data  output  WIDTH  converted value
- rsp_ready  input  1  consumer accepts result when high with rsp_valid
- busy  output  1  high when rsp_valid or any req is high
- conv_count  output  16  number of completed handshakes (rsp_valid & rsp_ready), saturating at 16'hFFFF

Behaviour:
- Reset, synchronous on rst=1:
  - rsp_valid=0, rsp_id=0, rsp_data=0, conv_count=0, round-robin pointer ptr=0, FSM=EMPTY.
  - gnt=0 while rst is high.
- FSM states:
  - EMPTY: no result held.
  - FULL: result held, waiting for the consumer.
- Accept condition: accept = (state==EMPTY) | (rsp_valid & rsp_ready).
- Grant:
  - When accept is true and req!=0, gnt asserts exactly one bit: the first set req bit searching ptr, ptr+1, ... (mod 4).
  - Otherwise gnt=0.
- On a grant to requester k, at the next rising edge:
  - rsp_data = conv(req_data[k], req_mode[k]), rsp_id = k, rsp_valid = 1, state = FULL.
  - ptr = (k+1) mod 4.
- Conversion functions:
  - binary->Gray: g = b ^ (b >> 1).
  - Gray->binary: b[MSB] = g[MSB]; b[i] = b[i+1] ^ g[i] for i = MSB-1 down to 0.
- Latency: 1 cycle from gnt to rsp_valid.
- Throughput: one result per cycle while rsp_ready stays high.
- Drain without refill: handshake completes and no req is set -> next edge rsp_valid=0, state=EMPTY.
- Backpressure: rsp_valid=1 and rsp_ready=0:
  - rsp_data and rsp_id hold stable.
  - gnt=0; ptr is unchanged.
- Requester rules:
  - A requester holds req, req_data and req_mode stable until it sees gnt.
  - Deasserting req before gnt withdraws the request; this is legal and nothing is recorded.
  - A requester may re-request in the cycle after its gnt.
- Simultaneous handshake and grant: the old result retires (conv_count increments) and the new result loads at the same edge; rsp_valid stays 1.
- conv_count: increments on each rsp_valid & rsp_ready edge and stops at 16'hFFFF.
- Reset mid-operation: any held result is discarded and not counted; pending requests are not granted until the cycle after rst falls.
- busy is combinational from rsp_valid and req.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then req=0 -> rsp_valid=0, gnt=0, conv_count=0, busy=0.
- Single binary->Gray:
  - req=0001, req_data[3:0]=4'b0100, mode=0 -> gnt=0001 same cycle.
  - Next cycle: rsp_valid=1, rsp_id=0, rsp_data=4'b0110.
  - Repeat with 4'b1111 -> 4'b1000.
- Gray->binary: requester 2, data 4'b1000, mode=1 -> rsp_id=2, rsp_data=4'b1111. Data 4'b0110 -> 4'b0100.
- Round-robin fairness: all 4 req held high, rsp_ready=1, from reset -> gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles; conv_count increments each cycle after the first result.
- Backpressure:
  - rsp_valid=1, rsp_ready=0 for 5 cycles with req=1111 -> gnt=0 and rsp_data/rsp_id stable throughout.
  - Raise rsp_ready -> the next grant goes to the requester after the last one granted.
- Reset mid-operation: rst pulsed while rsp_valid=1 and rsp_ready=0 -> next cycle rsp_valid=0, conv_count=0, ptr=0; then req=1010 -> first gnt=0010.

Source files
------------

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one registered binary/Gray converter
// between four requesters, with a tagged valid/ready result port.
module gray_conv_arbiter #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [3:0]           req,
   input  logic [4*WIDTH-1:0]   req_data,
   input  logic [3:0]           req_mode,
   output logic [3:0]           gnt,
   output logic                 rsp_valid,
   output logic [1:0]           rsp_id,
   output logic [WIDTH-1:0]     rsp_data,
   input  logic                 rsp_ready,
   output logic                 busy,
   output logic [15:0]          conv_count
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t             r_state;
   logic               r_rsp_valid;
   logic [1:0]         r_rsp_id;
   logic [WIDTH-1:0]   r_rsp_data;
   logic [1:0]         r_ptr;
   logic [15:0]        r_count;

   logic               w_accept;
   logic               w_hs;
   logic               w_any;
   logic [1:0]         w_idx;
   logic [1:0]         w_cand;
   logic [WIDTH-1:0]   w_sel_data;
   logic               w_sel_mode;
   logic [WIDTH-1:0]   w_conv;

   function automatic logic [WIDTH-1:0] bin2gray(
      input logic [WIDTH-1:0] b
   );
      return b ^ (b >> 1);
   endfunction

   function automatic logic [WIDTH-1:0] gray2bin(
      input logic [WIDTH-1:0] g
   );
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   assign w_hs     = r_rsp_valid & rsp_ready;
   assign w_accept = ~rst & ((r_state == EMPTY) | w_hs);

   // Rotating search starting at r_ptr; first set request wins.
   always_comb begin
      w_any  = 1'b0;
      w_idx  = r_ptr;
      w_cand = r_ptr;
      for (int i = 0; i < 4; i++) begin
         w_cand = r_ptr + 2'(i);
         if (!w_any && req[w_cand]) begin
            w_any = 1'b1;
            w_idx = w_cand;
         end
      end
      w_any = w_any & w_accept;
   end

   assign gnt = w_any ? (4'b0001 << w_idx) : 4'b0000;

   assign w_sel_data = req_data[w_idx*WIDTH +: WIDTH];
   assign w_sel_mode = req_mode[w_idx];
   assign w_conv     = w_sel_mode ? gray2bin(w_sel_data)
                                  : bin2gray(w_sel_data);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= EMPTY;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= 2'd0;
         r_rsp_data  <= '0;
         r_ptr       <= 2'd0;
         r_count     <= 16'd0;
      end else begin
         if (w_hs && r_count != 16'hFFFF) begin
            r_count <= r_count + 16'd1;
         end
         // A new grant may load in the same edge the old result retires.
         if (w_any) begin
            r_state     <= FULL;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= w_idx;
            r_rsp_data  <= w_conv;
            r_ptr       <= w_idx + 2'd1;
         end else if (w_hs) begin
            r_state     <= EMPTY;
            r_rsp_valid <= 1'b0;
         end
      end
   end

   assign rsp_valid  = r_rsp_valid;
   assign rsp_id     = r_rsp_id;
   assign rsp_data   = r_rsp_data;
   assign conv_count = r_count;
   assign busy       = r_rsp_valid | (|req);

endmodule
